pll_phase_ctrl: RTL and testbench
=================================

// Module: pll_phase_ctrl
// PURPOSE
//  Lock supervisor + dynamic phase-step sequencer for an ECP5 EHXPLLL, on the PLL reference clock.
//  Filters LOCK, restarts the PLL on lock timeout, and on request emits PHASESEL/PHASEDIR/PHASESTEP.
//  Tracks per-output phase position so SDRAM/SRAM capture clocks can be trimmed at runtime.
//  Sits beside the PLL instance; drives its RST and dynamic-phase pins, gates downstream resets.
// PARAMETERS
//  NUM_CH       4     outputs with phase control (1..4); maps to PHASESEL 0..NUM_CH-1
//  PHASE_STEPS  32    phase steps per output period; phase counter wraps modulo this
//  CNT_W        5     width of req_count
//  STEP_SETUP   4     cycles PHASESEL/PHASEDIR stable before and after each PHASESTEP pulse
//  STEP_WIDTH   2     PHASESTEP low-pulse width, cycles
//  LOCK_FILTER  1024  consecutive synced-high LOCK cycles before locked asserts
//  LOCK_TIMEOUT 2^20  cycles in WAIT_LOCK before forcing a PLL reset
//  RST_PULSE    16    pll_rst high width, cycles
// PORTS
//  clk          in   1      PLL reference clock
//  rst_n        in   1      async active-low reset
//  pll_lock     in   1      raw EHXPLLL LOCK (asynchronous to clk)
//  pll_rst      out  1      to EHXPLLL RST
//  phasesel     out  2      to PHASESEL1:0
//  phasedir     out  1      to PHASEDIR (1 = delay/late, 0 = advance)
//  phasestep    out  1      to PHASESTEP, idle high, active-low pulse
//  phaseloadreg out  1      to PHASELOADREG, tied high
//  locked       out  1      filtered lock
//  req_valid    in   1      phase request
//  req_ready    out  1      request accepted when valid&ready
//  req_ch       in   2      output index; >= NUM_CH -> rejected
//  req_dir      in   1      direction for all steps of request
//  req_count    in   CNT_W  number of steps
//  done         out  1      1-cycle pulse when request completes or is rejected
//  err          out  1      1-cycle pulse: rejected request or abort on lock loss
//  phase_pos    out  NUM_CH*5 current step position per channel, ch0 in LSBs (clog2(PHASE_STEPS) each)
//  relock_cnt   out  8      PLL resets issued by timeout, saturates at 255
// BEHAVIOUR
//  Reset: state=RESET_PLL, pll_rst=1, phasestep=1, phasesel=0, phasedir=0, locked=0, req_ready=0,
//   done=err=0, phase_pos=0, relock_cnt=0; all counters 0.
//  LOCK: 2-FF synchroniser; filter counter counts synced-high cycles, clears on any low.
//  locked rises the cycle the filter reaches LOCK_FILTER; falls the cycle after synced LOCK low.
//  States: RESET_PLL -> WAIT_LOCK -> IDLE -> SETUP -> PULSE -> HOLD -> (SETUP|IDLE).
//  RESET_PLL: pll_rst=1 for RST_PULSE cycles, phase_pos cleared to 0, then WAIT_LOCK.
//  WAIT_LOCK: pll_rst=0; locked -> IDLE; timer reaching LOCK_TIMEOUT -> RESET_PLL, relock_cnt+1 sat.
//  IDLE: req_ready = locked. On accept latch ch/dir/count (registered, 1 cycle).
//   ch >= NUM_CH or count==0: no pulses, done=1 next cycle; err=1 only for bad ch; stay IDLE.
//   else phasesel/phasedir driven from latch, -> SETUP.
//  SETUP: STEP_SETUP cycles, phasestep=1. PULSE: STEP_WIDTH cycles, phasestep=0.
//  HOLD: STEP_SETUP cycles, phasestep=1; on exit phase_pos[ch] +/-1 mod PHASE_STEPS
//   (dir=1 increments, 31+1->0, 0-1->31), remaining-1; remaining 0 -> done pulse, IDLE; else SETUP.
//  Per step: 2*STEP_SETUP+STEP_WIDTH cycles; phasesel/phasedir stable for whole request.
//  Lock loss (locked falls) in IDLE/SETUP/PULSE/HOLD: phasestep=1 next cycle, err pulse if a
//   request was in flight (no done), -> WAIT_LOCK; phase_pos keeps completed steps only.
//  A step is counted only on HOLD exit; aborted mid-pulse step is not counted.
//  req_ready=0 outside IDLE; requests held by the master are not lost.
//  rst_n low mid-operation: immediate return to reset values, phasestep high asynchronously.
// TESTING
//  Reset release, pll_lock high at cycle 10 -> pll_rst low after 16 cycles, locked 1024+2..3 later.
//  req ch=1 dir=1 count=3 -> phasesel=1, 3 low pulses of 2 cycles, 10-cycle pitch; phase_pos[1]=3, done.
//  ch=2 dir=0 count=1 from 0 -> phase_pos[2]=31 (wrap); then dir=1 count=1 -> 0.
//  req ch=3 with NUM_CH=2 -> no pulses, done+err same cycle; count=0 -> done only.
//  Drop pll_lock during 2nd PULSE of count=4 -> err, phase_pos +1 only, WAIT_LOCK, relock resumes.
//  pll_lock held low (LOCK_TIMEOUT=64 in test) -> pll_rst pulses every 64+16 cycles, relock_cnt 1,2,3.

Source files
------------

// File: rtl/pll_phase_ctrl_if.sv
// rtl/pll_phase_ctrl_if.sv - phase-step request/response bus for pll_phase_ctrl
interface pll_phase_ctrl_if #(
    parameter int CNT_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_ch;
    logic             req_dir;
    logic [CNT_W-1:0] req_count;
    logic             done;
    logic             err;

    modport master (
        output req_valid, req_ch, req_dir, req_count,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_ch, req_dir, req_count,
        output req_ready, done, err
    );
endinterface

// File: rtl/pll_phase_ctrl.sv
// rtl/pll_phase_ctrl.sv - EHXPLLL lock supervisor and dynamic phase-step sequencer
module pll_phase_ctrl #(
    parameter int NUM_CH       = 4,
    parameter int PHASE_STEPS  = 32,
    parameter int CNT_W        = 5,
    parameter int STEP_SETUP   = 4,
    parameter int STEP_WIDTH   = 2,
    parameter int LOCK_FILTER  = 1024,
    parameter int LOCK_TIMEOUT = 1 << 20,
    parameter int RST_PULSE    = 16,
    localparam int POS_W       = $clog2(PHASE_STEPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_lock,
    output logic                    pll_rst,
    output logic [1:0]              phasesel,
    output logic                    phasedir,
    output logic                    phasestep,
    output logic                    phaseloadreg,
    output logic                    locked,
    pll_phase_ctrl_if.slave         req,
    output logic [NUM_CH*POS_W-1:0] phase_pos,
    output logic [7:0]              relock_cnt
);
    localparam int FILT_W = $clog2(LOCK_FILTER + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD
    } state_t;

    state_t           state;
    logic [31:0]      cnt;
    logic             pend;
    logic [1:0]       lat_ch;
    logic             lat_dir;
    logic [CNT_W-1:0] lat_count;
    logic [POS_W-1:0] pos [NUM_CH];

    logic              lock_s1, lock_s2;
    logic [FILT_W-1:0] filt_cnt;

    assign phaseloadreg  = 1'b1;
    assign req.req_ready = (state == S_IDLE) && locked && !pend;

    always_comb begin
        phase_pos = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            phase_pos[i*POS_W +: POS_W] = pos[i];
        end
    end

    // LOCK is asynchronous; locked needs LOCK_FILTER unbroken synced-high cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_s1  <= 1'b0;
            lock_s2  <= 1'b0;
            filt_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            lock_s1 <= pll_lock;
            lock_s2 <= lock_s1;
            if (!lock_s2) begin
                filt_cnt <= '0;
                locked   <= 1'b0;
            end else if (filt_cnt < FILT_W'(LOCK_FILTER)) begin
                filt_cnt <= filt_cnt + 1'b1;
                if (filt_cnt == FILT_W'(LOCK_FILTER - 1)) begin
                    locked <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RESET_PLL;
            cnt        <= '0;
            pend       <= 1'b0;
            lat_ch     <= '0;
            lat_dir    <= 1'b0;
            lat_count  <= '0;
            pll_rst    <= 1'b1;
            phasesel   <= '0;
            phasedir   <= 1'b0;
            phasestep  <= 1'b1;
            req.done   <= 1'b0;
            req.err    <= 1'b0;
            relock_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pos[i] <= '0;
            end
        end else begin
            req.done <= 1'b0;
            req.err  <= 1'b0;
            if (state != S_RESET_PLL && state != S_WAIT_LOCK && !locked) begin
                // lock lost: abandon the partial step, its position is never counted
                state     <= S_WAIT_LOCK;
                phasestep <= 1'b1;
                cnt       <= '0;
                pend      <= 1'b0;
                req.err   <= pend || (state != S_IDLE);
            end else begin
                case (state)
                    S_RESET_PLL: begin
                        pll_rst <= 1'b1;
                        for (int i = 0; i < NUM_CH; i++) begin
                            pos[i] <= '0;
                        end
                        if (cnt == 32'(RST_PULSE - 1)) begin
                            state   <= S_WAIT_LOCK;
                            pll_rst <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (locked) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end else if (cnt == 32'(LOCK_TIMEOUT - 1)) begin
                            state   <= S_RESET_PLL;
                            pll_rst <= 1'b1;
                            cnt     <= '0;
                            if (relock_cnt != 8'hff) begin
                                relock_cnt <= relock_cnt + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_IDLE: begin
                        if (pend) begin
                            pend <= 1'b0;
                            if (int'(lat_ch) >= NUM_CH || lat_count == '0) begin
                                req.done <= 1'b1;
                                req.err  <= int'(lat_ch) >= NUM_CH;
                            end else begin
                                phasesel <= lat_ch;
                                phasedir <= lat_dir;
                                cnt      <= '0;
                                state    <= S_SETUP;
                            end
                        end else if (req.req_valid && req.req_ready) begin
                            lat_ch    <= req.req_ch;
                            lat_dir   <= req.req_dir;
                            lat_count <= req.req_count;
                            pend      <= 1'b1;
                        end
                    end
                    S_SETUP: begin
                        if (cnt == 32'(STEP_SETUP - 1)) begin
                            state     <= S_PULSE;
                            phasestep <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_PULSE: begin
                        if (cnt == 32'(STEP_WIDTH - 1)) begin
                            state     <= S_HOLD;
                            phasestep <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (cnt == 32'(STEP_SETUP - 1)) begin
                            cnt <= '0;
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (lat_ch == i[1:0]) begin
                                    if (lat_dir) begin
                                        pos[i] <= (pos[i] == POS_W'(PHASE_STEPS - 1)) ? '0 : pos[i] + 1'b1;
                                    end else begin
                                        pos[i] <= (pos[i] == '0) ? POS_W'(PHASE_STEPS - 1) : pos[i] - 1'b1;
                                    end
                                end
                            end
                            lat_count <= lat_count - 1'b1;
                            if (lat_count == CNT_W'(1)) begin
                                req.done <= 1'b1;
                                state    <= S_IDLE;
                            end else begin
                                state <= S_SETUP;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= S_RESET_PLL;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb/tb_pll_phase_ctrl.sv - scoreboard bench for pll_phase_ctrl
module tb_pll_phase_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n, lock_a, lock_b;
    logic pll_rst_a, phasedir_a, phasestep_a, plr_a, locked_a;
    logic pll_rst_b, phasedir_b, phasestep_b, plr_b, locked_b;
    logic [1:0]  phasesel_a, phasesel_b;
    logic [19:0] pos_a;
    logic [9:0]  pos_b;
    logic [7:0]  relock_a, relock_b;

    pll_phase_ctrl_if ifa ();
    pll_phase_ctrl_if ifb ();

    pll_phase_ctrl #(.NUM_CH(4)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .pll_lock(lock_a), .pll_rst(pll_rst_a),
        .phasesel(phasesel_a), .phasedir(phasedir_a), .phasestep(phasestep_a),
        .phaseloadreg(plr_a), .locked(locked_a), .req(ifa.slave),
        .phase_pos(pos_a), .relock_cnt(relock_a)
    );

    pll_phase_ctrl #(.NUM_CH(2), .LOCK_FILTER(16), .LOCK_TIMEOUT(64)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .pll_lock(lock_b), .pll_rst(pll_rst_b),
        .phasesel(phasesel_b), .phasedir(phasedir_b), .phasestep(phasestep_b),
        .phaseloadreg(plr_b), .locked(locked_b), .req(ifb.slave),
        .phase_pos(pos_b), .relock_cnt(relock_b)
    );

    typedef struct packed {
        logic        done;
        logic        err;
        logic [19:0] pos;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    logic [1:0] exp_sel = 2'd0;
    logic [4:0] ea [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [19:0] pack_a();
        return {ea[3], ea[2], ea[1], ea[0]};
    endfunction

    // Monitor for dut_a: scoreboard on done/err plus pulse width, pitch and select checks
    int low_a = 0;
    int last_fall_a = -1000;
    always @(negedge clk) begin
        if (rst_a_n && (ifa.done || ifa.err)) begin
            if (qa.size() == 0) begin
                chk("sb_a_unexpected", {30'd0, ifa.done, ifa.err}, 32'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("sb_a_done", 32'(ifa.done), 32'(e.done));
                chk("sb_a_err", 32'(ifa.err), 32'(e.err));
                chk("sb_a_pos", 32'(pos_a), 32'(e.pos));
            end
        end
        if (!rst_a_n) begin
            low_a = 0;
        end else if (!phasestep_a) begin
            if (low_a == 0) begin
                chk("pulse_sel_a", 32'(phasesel_a), 32'(exp_sel));
                if (cyc - last_fall_a <= 20) chk("pulse_pitch_a", cyc - last_fall_a, 10);
                last_fall_a = cyc;
            end
            low_a++;
        end else if (low_a > 0) begin
            chk("pulse_width_a", low_a, 2);
            pulses_a++;
            low_a = 0;
        end
    end

    logic prev_step_b = 1'b1;
    always @(negedge clk) begin
        if (rst_b_n && (ifb.done || ifb.err)) begin
            if (qb.size() == 0) begin
                chk("sb_b_unexpected", {30'd0, ifb.done, ifb.err}, 32'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("sb_b_done", 32'(ifb.done), 32'(e.done));
                chk("sb_b_err", 32'(ifb.err), 32'(e.err));
                chk("sb_b_pos", 32'(pos_b), 32'(e.pos));
            end
        end
        if (prev_step_b && !phasestep_b) pulses_b++;
        prev_step_b = phasestep_b;
    end

    task automatic send(input bit b, input int ch, input bit dir, input int n);
        bit ok, rdy;
        @(negedge clk);
        if (b) begin
            ifb.req_valid = 1'b1; ifb.req_ch = 2'(ch); ifb.req_dir = dir; ifb.req_count = 5'(n);
        end else begin
            ifa.req_valid = 1'b1; ifa.req_ch = 2'(ch); ifa.req_dir = dir; ifa.req_count = 5'(n);
        end
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            rdy = b ? ifb.req_ready : ifa.req_ready;
            @(negedge clk);
            if (rdy) ok = 1'b1;
        end
        ifa.req_valid = 1'b0;
        ifb.req_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_empty(input bit b, input string name);
        for (int i = 0; i < 500; i++) begin
            if ((b ? qb.size() : qa.size()) == 0) break;
            @(negedge clk);
        end
        chk(name, b ? qb.size() : qa.size(), 0);
    endtask

    task automatic wait_ready(input bit b, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = b ? ifb.req_ready : ifa.req_ready;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_fall_a(input int nfalls);
        int falls;
        logic prev;
        falls = 0;
        prev = phasestep_a;
        for (int i = 0; i < 500 && falls < nfalls; i++) begin
            @(negedge clk);
            if (prev && !phasestep_a) falls++;
            prev = phasestep_a;
        end
        chk("fall_timeout_a", falls, nfalls);
    endtask

    task automatic run_a(input int ch, input bit dir, input int n);
        int base;
        base = pulses_a;
        exp_sel = 2'(ch);
        ea[ch] = dir ? ea[ch] + 5'(n) : ea[ch] - 5'(n);
        qa.push_back('{done: 1'b1, err: 1'b0, pos: pack_a()});
        send(1'b0, ch, dir, n);
        wait_empty(1'b0, "done_timeout_a");
        chk("pulse_count_a", pulses_a - base, n);
        chk("phasedir_a", 32'(phasedir_a), 32'(dir));
        repeat (30) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, gap, base;
        for (int i = 0; i < 4; i++) ea[i] = 5'd0;
        rst_a_n = 1'b0; rst_b_n = 1'b0; lock_a = 1'b0; lock_b = 1'b0;
        ifa.req_valid = 1'b0; ifa.req_ch = '0; ifa.req_dir = 1'b0; ifa.req_count = '0;
        ifb.req_valid = 1'b0; ifb.req_ch = '0; ifb.req_dir = 1'b0; ifb.req_count = '0;
        repeat (3) @(negedge clk);
        chk("rst_pll_rst", 32'(pll_rst_a), 32'd1);
        chk("rst_phasestep", 32'(phasestep_a), 32'd1);
        chk("rst_locked", 32'(locked_a), 32'd0);
        chk("rst_ready", 32'(ifa.req_ready), 32'd0);
        chk("rst_pos", 32'(pos_a), 32'd0);
        chk("rst_relock", 32'(relock_a), 32'd0);
        chk("rst_phaseloadreg", 32'(plr_a), 32'd1);
        chk("rst_done_err", {30'd0, ifa.done, ifa.err}, 32'd0);

        rst_a_n = 1'b1;
        repeat (10) @(negedge clk);
        lock_a = 1'b1;
        repeat (5) @(negedge clk);
        chk("pll_rst_cycle15", 32'(pll_rst_a), 32'd1);
        @(negedge clk);
        chk("pll_rst_cycle16", 32'(pll_rst_a), 32'd0);
        repeat (1019) @(negedge clk);
        chk("locked_cycle1035", 32'(locked_a), 32'd0);
        @(negedge clk);
        chk("locked_cycle1036", 32'(locked_a), 32'd1);
        wait_ready(1'b0, 20, "ready_after_lock_a");

        run_a(1, 1'b1, 3);
        run_a(2, 1'b0, 1);
        chk("pos2_wrap_down", 32'(pos_a[14:10]), 32'd31);
        run_a(2, 1'b1, 1);
        chk("pos2_wrap_up", 32'(pos_a[14:10]), 32'd0);

        // abort during the second pulse of a four-step request
        base = pulses_a;
        exp_sel = 2'd0;
        ea[0] = ea[0] + 5'd1;
        qa.push_back('{done: 1'b0, err: 1'b1, pos: pack_a()});
        send(1'b0, 0, 1'b1, 4);
        wait_fall_a(2);
        lock_a = 1'b0;
        wait_empty(1'b0, "abort_timeout_a");
        repeat (5) @(negedge clk);
        chk("abort_pulses_a", pulses_a - base, 2);
        chk("abort_phasestep", 32'(phasestep_a), 32'd1);
        chk("abort_ready", 32'(ifa.req_ready), 32'd0);
        chk("abort_pll_rst", 32'(pll_rst_a), 32'd0);
        lock_a = 1'b1;
        wait_ready(1'b0, 1200, "relock_ready_a");
        run_a(3, 1'b0, 2);

        // asynchronous reset in the middle of a pulse
        exp_sel = 2'd1;
        send(1'b0, 1, 1'b1, 2);
        wait_fall_a(1);
        #2 rst_a_n = 1'b0;
        #1;
        chk("async_phasestep", 32'(phasestep_a), 32'd1);
        chk("async_pll_rst", 32'(pll_rst_a), 32'd1);
        chk("async_pos", 32'(pos_a), 32'd0);
        chk("async_locked", 32'(locked_a), 32'd0);
        repeat (3) @(negedge clk);

        // second instance: two channels, short filter and timeout
        rst_b_n = 1'b1;
        lock_b = 1'b1;
        wait_ready(1'b1, 200, "ready_after_lock_b");
        qb.push_back('{done: 1'b1, err: 1'b1, pos: 20'd0});
        send(1'b1, 3, 1'b1, 2);
        wait_empty(1'b1, "badch_timeout_b");
        qb.push_back('{done: 1'b1, err: 1'b0, pos: 20'd0});
        send(1'b1, 1, 1'b1, 0);
        wait_empty(1'b1, "zero_timeout_b");
        qb.push_back('{done: 1'b1, err: 1'b1, pos: 20'd0});
        send(1'b1, 2, 1'b0, 1);
        wait_empty(1'b1, "badch2_timeout_b");
        repeat (10) @(negedge clk);
        chk("no_pulses_b", pulses_b, 0);

        lock_b = 1'b0;
        t0 = -1;
        for (int k = 1; k <= 3; k++) begin
            bit seen;
            logic prev;
            seen = 1'b0;
            prev = pll_rst_b;
            for (int i = 0; i < 300 && !seen; i++) begin
                @(negedge clk);
                if (!prev && pll_rst_b) seen = 1'b1;
                prev = pll_rst_b;
            end
            chk("timeout_seen_b", 32'(seen), 32'd1);
            chk("relock_cnt_b", 32'(relock_b), 32'(k));
            if (t0 >= 0) begin
                gap = cyc - t0;
                chk("timeout_period_b", gap, 80);
            end
            t0 = cyc;
        end
        chk("locked_b_low", 32'(locked_b), 32'd0);
        chk("queue_a_empty", qa.size(), 0);
        chk("queue_b_empty", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
